// File: rtl/bf_alu_pkg.sv
// bf_alu_pkg: shared types and helpers for the Brainfuck cell ALU.
// Provides the default cell width, the op encoding and the select decoder.
package bf_alu_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_PASS    = 2'd0,
        OP_DEC     = 2'd1,
        OP_INC     = 2'd2,
        OP_ILLEGAL = 2'd3
    } alu_op_e;

    // Any select pattern other than exactly one strobe high is illegal.
    function automatic alu_op_e decode_op(
        input logic nochange,
        input logic decrement,
        input logic increment
    );
        alu_op_e op;
        case ({nochange, decrement, increment})
            3'b100:  op = OP_PASS;
            3'b010:  op = OP_DEC;
            3'b001:  op = OP_INC;
            default: op = OP_ILLEGAL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/bf_alu_decode.sv
// bf_alu_decode: one-hot check of the three ALU select strobes.
// Produces the decoded op and an illegal flag for non-one-hot selects.
module bf_alu_decode
    import bf_alu_pkg::*;
(
    input  logic    i_nochange,
    input  logic    i_decrement,
    input  logic    i_increment,
    output alu_op_e o_op,
    output logic    o_illegal
);

    alu_op_e w_op;

    // Decode the strobes into a single op.
    always_comb begin
        w_op = decode_op(i_nochange, i_decrement, i_increment);
    end

    assign o_op      = w_op;
    assign o_illegal = (w_op == OP_ILLEGAL);

endmodule

// File: rtl/bf_alu.sv
// bf_alu: Brainfuck cell ALU (pass / decrement / increment) with flags.
// Define BF_ALU_ERR_STICKY_EN to make err_sticky latch illegal selects.
module bf_alu
    import bf_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             nochange,
    input  logic             decrement,
    input  logic             increment,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             wrap,
    output logic             illegal,
    output logic [WIDTH-1:0] out_q,
    output logic             wrap_q,
    output logic             valid_q,
    output logic             err_sticky
);

    alu_op_e          w_op;
    logic             w_illegal;
    logic [WIDTH-1:0] w_out;
    logic             w_wrap;

    logic [WIDTH-1:0] r_out;
    logic             r_wrap;
    logic             r_valid;

    bf_alu_decode u_decode (
        .i_nochange  (nochange),
        .i_decrement (decrement),
        .i_increment (increment),
        .o_op        (w_op),
        .o_illegal   (w_illegal)
    );

    // Cell arithmetic; illegal selects pass the cell through unchanged.
    always_comb begin
        w_out  = a;
        w_wrap = 1'b0;
        unique case (w_op)
            OP_DEC: begin
                w_out  = a - WIDTH'(1);
                w_wrap = (a == '0);
            end
            OP_INC: begin
                w_out  = a + WIDTH'(1);
                w_wrap = (a == '1);
            end
            default: begin
                w_out  = a;
                w_wrap = 1'b0;
            end
        endcase
    end

    // Registered copy of the result for the control unit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= '0;
            r_wrap  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_out   <= w_out;
            r_wrap  <= w_wrap;
            r_valid <= !w_illegal;
        end
    end

`ifdef BF_ALU_ERR_STICKY_EN
    logic r_err;

    // Latch any illegal select until the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_illegal) begin
            r_err <= 1'b1;
        end
    end

    assign err_sticky = r_err;
`else
    assign err_sticky = 1'b0;
`endif

    assign out     = w_out;
    assign zero    = (w_out == '0);
    assign wrap    = w_wrap;
    assign illegal = w_illegal;
    assign out_q   = r_out;
    assign wrap_q  = r_wrap;
    assign valid_q = r_valid;

endmodule

// File: tb/tb_bf_alu.sv
// tb_bf_alu: self-checking bench for bf_alu.
// Directed cases plus random stimulus against an arithmetic reference model.
module tb_bf_alu;

    localparam int W = 8;
    localparam int MOD = 1 << W;
`ifdef BF_ALU_ERR_STICKY_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a = '0;
    logic         nochange = 1'b0;
    logic         decrement = 1'b0;
    logic         increment = 1'b0;

    logic [W-1:0] out;
    logic         zero;
    logic         wrap;
    logic         illegal;
    logic [W-1:0] out_q;
    logic         wrap_q;
    logic         valid_q;
    logic         err_sticky;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] m_out_q = '0;
    logic         m_wrap_q = 1'b0;
    logic         m_valid_q = 1'b0;
    logic         m_sticky = 1'b0;

    bf_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .nochange   (nochange),
        .decrement  (decrement),
        .increment  (increment),
        .out        (out),
        .zero       (zero),
        .wrap       (wrap),
        .illegal    (illegal),
        .out_q      (out_q),
        .wrap_q     (wrap_q),
        .valid_q    (valid_q),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    // Reference: plain modular arithmetic on integers.
    function automatic void ref_comb(
        input  logic [W-1:0] av,
        input  logic         n,
        input  logic         d,
        input  logic         i,
        output logic [W-1:0] o,
        output logic         z,
        output logic         wr,
        output logic         il
    );
        int cnt;
        int v;
        cnt = int'(n) + int'(d) + int'(i);
        v   = int'(av);
        il  = (cnt != 1);
        o   = av;
        wr  = 1'b0;
        if (!il && i) begin
            o  = W'((v + 1) % MOD);
            wr = (v == MOD - 1);
        end else if (!il && d) begin
            o  = W'((v - 1 + MOD) % MOD);
            wr = (v == 0);
        end
        z = (o == 0);
    endfunction

    task automatic apply(input logic [W-1:0] av, input logic n,
                         input logic d, input logic i);
        a = av;
        nochange = n;
        decrement = d;
        increment = i;
        #1;
    endtask

    // Advance one rising edge and update the registered model.
    task automatic clk_edge();
        logic [W-1:0] o;
        logic z, wr, il;
        @(posedge clk);
        ref_comb(a, nochange, decrement, increment, o, z, wr, il);
        if (rst) begin
            m_out_q = '0;
            m_wrap_q = 1'b0;
            m_valid_q = 1'b0;
            m_sticky = 1'b0;
        end else begin
            m_out_q = o;
            m_wrap_q = wr;
            m_valid_q = !il;
            if (STICKY_EN && il) m_sticky = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(8'h5A, 1'b1, 1'b0, 1'b0);
        clk_edge();
        checks++;
        if ({out_q, wrap_q, valid_q, err_sticky} !== {8'h00, 3'b000}) begin
            errors++;
            $display("FAIL reset_regs: got %h/%b/%b/%b want 00/0/0/0",
                     out_q, wrap_q, valid_q, err_sticky);
        end
        checks++;
        if ({out, illegal} !== {8'h5A, 1'b0}) begin
            errors++;
            $display("FAIL reset_comb: got out=%h il=%b want 5a/0", out, illegal);
        end
        rst = 1'b0;
    endtask

    task automatic test_ops();
        logic [W-1:0] o;
        logic z, wr, il;
        for (int k = 0; k < 3; k++) begin
            apply(8'hAD, k == 0, k == 1, k == 2);
            ref_comb(a, nochange, decrement, increment, o, z, wr, il);
            checks++;
            if ({out, zero, wrap, illegal} !== {o, z, wr, il}) begin
                errors++;
                $display("FAIL op_%0d: got %h/%b/%b/%b want %h/%b/%b/%b", k,
                         out, zero, wrap, illegal, o, z, wr, il);
            end
        end
        apply(8'hAD, 1'b0, 1'b0, 1'b1);
        checks++;
        if (out !== 8'hAE) begin
            errors++;
            $display("FAIL inc_const: got %h want ae", out);
        end
    endtask

    task automatic test_wrap();
        apply(8'hFF, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({out, zero, wrap, illegal} !== {8'h00, 3'b110}) begin
            errors++;
            $display("FAIL wrap_inc: got %h/%b/%b/%b want 00/1/1/0",
                     out, zero, wrap, illegal);
        end
        apply(8'h00, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({out, zero, wrap, illegal} !== {8'hFF, 3'b010}) begin
            errors++;
            $display("FAIL wrap_dec: got %h/%b/%b/%b want ff/0/1/0",
                     out, zero, wrap, illegal);
        end
    endtask

    task automatic test_illegal();
        apply(8'h42, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({out, wrap, illegal} !== {8'h42, 2'b01}) begin
            errors++;
            $display("FAIL illegal_two: got %h/%b/%b want 42/0/1",
                     out, wrap, illegal);
        end
        apply(8'h42, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({out, wrap, illegal} !== {8'h42, 2'b01}) begin
            errors++;
            $display("FAIL illegal_none: got %h/%b/%b want 42/0/1",
                     out, wrap, illegal);
        end
        apply(8'h00, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({out, zero, wrap, illegal} !== {8'h00, 3'b101}) begin
            errors++;
            $display("FAIL illegal_zero: got %h/%b/%b/%b want 00/1/0/1",
                     out, zero, wrap, illegal);
        end
    endtask

    task automatic test_registered();
        apply(8'h10, 1'b0, 1'b0, 1'b1);
        clk_edge();
        checks++;
        if ({out_q, wrap_q, valid_q} !== {8'h11, 2'b01}) begin
            errors++;
            $display("FAIL reg_inc: got %h/%b/%b want 11/0/1",
                     out_q, wrap_q, valid_q);
        end
        rst = 1'b1;
        clk_edge();
        rst = 1'b0;
        checks++;
        if ({out_q, wrap_q, valid_q} !== {8'h00, 2'b00}) begin
            errors++;
            $display("FAIL reg_rst: got %h/%b/%b want 00/0/0",
                     out_q, wrap_q, valid_q);
        end
    endtask

    task automatic test_sticky();
        apply(8'h33, 1'b1, 1'b1, 1'b0);
        clk_edge();
        for (int k = 0; k < 3; k++) begin
            apply(8'(k), 1'b1, 1'b0, 1'b0);
            clk_edge();
            checks++;
            if (err_sticky !== STICKY_EN) begin
                errors++;
                $display("FAIL sticky_hold_%0d: got %b want %b",
                         k, err_sticky, STICKY_EN);
            end
        end
        rst = 1'b1;
        clk_edge();
        rst = 1'b0;
        checks++;
        if (err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clear: got %b want 0", err_sticky);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] o;
        logic z, wr, il;
        logic [2:0] sel;
        for (int k = 0; k < 300; k++) begin
            sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) sel = 3'b1 << $urandom_range(0, 2);
            rst = ($urandom_range(0, 15) == 0);
            apply(W'($urandom), sel[2], sel[1], sel[0]);
            ref_comb(a, nochange, decrement, increment, o, z, wr, il);
            checks++;
            if ({out, zero, wrap, illegal} !== {o, z, wr, il}) begin
                errors++;
                $display("FAIL rand_comb_%0d: got %h/%b/%b/%b want %h/%b/%b/%b",
                         k, out, zero, wrap, illegal, o, z, wr, il);
            end
            clk_edge();
            checks++;
            if ({out_q, wrap_q, valid_q, err_sticky} !==
                {m_out_q, m_wrap_q, m_valid_q, m_sticky}) begin
                errors++;
                $display("FAIL rand_reg_%0d: got %h/%b/%b/%b want %h/%b/%b/%b",
                         k, out_q, wrap_q, valid_q, err_sticky,
                         m_out_q, m_wrap_q, m_valid_q, m_sticky);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ops();
        test_wrap();
        test_illegal();
        test_registered();
        test_sticky();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
